rx_ltssm_substate: RTL and testbench

//  Receive-side LTSSM substate engine; sits directly upstream of mainLTSSM.

---
 rtl/pcie_ltssm_pkg.sv | 29 ++
 rtl/os_match_counter.sv | 21 ++
 rtl/rx_ltssm_substate.sv | 181 ++++++++++++++++++
 tb/tb_rx_ltssm_substate.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_ltssm_pkg.sv
// rtl/pcie_ltssm_pkg.sv - shared LTSSM substate codes, ordered-set types and TS counts
package pcie_ltssm_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET          = 4'd0,
    DETECT_ACTIVE         = 4'd1,
    POLLING_ACTIVE        = 4'd2,
    POLLING_CONFIGURATION = 4'd3,
    CFG_LINKWIDTH_START   = 4'd4,
    CFG_LINKWIDTH_ACCEPT  = 4'd5,
    CFG_LANENUM_WAIT      = 4'd6,
    CFG_LANENUM_ACCEPT    = 4'd7,
    CFG_COMPLETE          = 4'd8,
    CFG_IDLE              = 4'd9,
    L0                    = 4'd10
  } substate_t;

  typedef enum logic [1:0] {
    OS_OTHER = 2'b00,
    OS_TS1   = 2'b01,
    OS_TS2   = 2'b10,
    OS_IDL   = 2'b11
  } os_type_t;

  localparam logic [7:0] PAD            = 8'hF7;
  localparam logic [3:0] TS_COUNT_LONG  = 4'd8;
  localparam logic [3:0] TS_COUNT_SHORT = 4'd2;

endpackage

// File: rtl/os_match_counter.sv
// rtl/os_match_counter.sv - saturating 4-bit consecutive ordered-set counter
// clr wins over inc; neither asserted holds the count.
module os_match_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc && count != 4'hF) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/rx_ltssm_substate.sv
// rtl/rx_ltssm_substate.sv - receive-side LTSSM substate exit detector
// Tracks the commanded substate, counts qualifying ordered sets and raises finishRx/gotoRx.
module rx_ltssm_substate
  import pcie_ltssm_pkg::*;
#(
  parameter int DEVICETYPE     = 0,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int QUIET_CYCLES   = 12000,
  parameter int IDLE_TIMEOUT   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] substateRx,
  input  logic       osValid,
  input  logic [1:0] osType,
  input  logic [7:0] osLinkNumber,
  input  logic [7:0] osLaneNumber,
  input  logic [7:0] osRateId,
  input  logic       rxElecIdleExit,
  input  logic       detectDone,
  input  logic       receiverDetected,
  output logic       finishRx,
  output logic [3:0] gotoRx,
  output logic [7:0] linkNumberInRx,
  output logic       writeLinkNumberRx,
  output logic [7:0] rateIdIn,
  output logic       writeRateId
);

  logic [3:0]  tracked_state;
  logic        finish_q;
  logic [31:0] timer;
  logic [3:0]  count;

  logic        state_change;
  logic        active;
  logic        is_ts1;
  logic        is_ts2;
  logic        lane_pad;
  logic        link_pad;
  logic        match;
  logic [3:0]  need;
  logic [3:0]  os_target;
  logic [3:0]  timeout_target;
  logic        direct_exit;
  logic        timeout_hit;
  logic        os_exit;

  assign state_change = substateRx != tracked_state;
  assign active       = tracked_state <= CFG_IDLE;
  assign is_ts1       = osType == OS_TS1;
  assign is_ts2       = osType == OS_TS2;
  assign lane_pad     = osLaneNumber == PAD;
  assign link_pad     = osLinkNumber == PAD;

  // Per-state qualifier, required run length, exit targets and timeout compare
  always_comb begin
    match          = 1'b0;
    need           = TS_COUNT_LONG;
    os_target      = DETECT_QUIET;
    timeout_target = DETECT_QUIET;
    direct_exit    = 1'b0;
    timeout_hit    = 1'b0;
    case (tracked_state)
      DETECT_QUIET: begin
        direct_exit    = rxElecIdleExit;
        os_target      = DETECT_ACTIVE;
        timeout_target = DETECT_ACTIVE;
        timeout_hit    = timer == 32'(QUIET_CYCLES);
      end
      DETECT_ACTIVE: begin
        direct_exit = detectDone;
        os_target   = receiverDetected ? POLLING_ACTIVE : DETECT_QUIET;
      end
      POLLING_ACTIVE: begin
        match       = (is_ts1 || is_ts2) && lane_pad;
        os_target   = POLLING_CONFIGURATION;
        timeout_hit = timer == 32'(TIMEOUT_CYCLES);
      end
      POLLING_CONFIGURATION: begin
        match       = is_ts2;
        os_target   = CFG_LINKWIDTH_START;
        timeout_hit = timer == 32'(TIMEOUT_CYCLES);
      end
      CFG_LINKWIDTH_START: begin
        match       = is_ts1 && !link_pad;
        need        = TS_COUNT_SHORT;
        os_target   = CFG_LINKWIDTH_ACCEPT;
        timeout_hit = timer == 32'(TIMEOUT_CYCLES);
      end
      CFG_LINKWIDTH_ACCEPT: begin
        match       = (DEVICETYPE == 1) && is_ts1 && osLinkNumber == linkNumberInRx && !lane_pad;
        need        = TS_COUNT_SHORT;
        os_target   = CFG_LANENUM_WAIT;
        timeout_hit = timer == 32'(TIMEOUT_CYCLES);
      end
      CFG_LANENUM_WAIT: begin
        match       = is_ts1 && !lane_pad;
        need        = TS_COUNT_SHORT;
        os_target   = CFG_LANENUM_ACCEPT;
        timeout_hit = timer == 32'(TIMEOUT_CYCLES);
      end
      CFG_LANENUM_ACCEPT: begin
        match       = is_ts2;
        need        = TS_COUNT_SHORT;
        os_target   = CFG_COMPLETE;
        timeout_hit = timer == 32'(TIMEOUT_CYCLES);
      end
      CFG_COMPLETE: begin
        match       = is_ts2 && osLinkNumber == linkNumberInRx;
        os_target   = CFG_IDLE;
        timeout_hit = timer == 32'(TIMEOUT_CYCLES);
      end
      CFG_IDLE: begin
        match       = osType == OS_IDL;
        os_target   = L0;
        timeout_hit = timer == 32'(IDLE_TIMEOUT);
      end
      default: begin
        match = 1'b0;
      end
    endcase
  end

  assign os_exit = direct_exit | (osValid & match & (count == need - 4'd1));

  os_match_counter u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (state_change | !active | (osValid & !match)),
    .inc   (osValid & match),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tracked_state     <= DETECT_QUIET;
      finish_q          <= 1'b0;
      gotoRx            <= DETECT_QUIET;
      timer             <= 32'd0;
      linkNumberInRx    <= 8'd0;
      writeLinkNumberRx <= 1'b0;
      rateIdIn          <= 8'd0;
      writeRateId       <= 1'b0;
    end else begin
      writeLinkNumberRx <= 1'b0;
      writeRateId       <= 1'b0;
      if (state_change) begin
        tracked_state <= substateRx;
        finish_q      <= 1'b0;
        timer         <= 32'd0;
      end else if (!active) begin
        timer <= 32'd0;
      end else begin
        if (timer != 32'hFFFF_FFFF) timer <= timer + 32'd1;
        // The OS exit takes precedence over a timeout landing on the same cycle
        if (!finish_q) begin
          if (os_exit) begin
            finish_q <= 1'b1;
            gotoRx   <= os_target;
            if (tracked_state == CFG_LINKWIDTH_START && DEVICETYPE == 1) begin
              linkNumberInRx    <= osLinkNumber;
              writeLinkNumberRx <= 1'b1;
            end
            if (tracked_state == CFG_COMPLETE) begin
              rateIdIn    <= osRateId;
              writeRateId <= 1'b1;
            end
          end else if (timeout_hit) begin
            finish_q <= 1'b1;
            gotoRx   <= timeout_target;
          end
        end
      end
    end
  end

  // Drop finish in the same cycle mainLTSSM moves on
  assign finishRx = finish_q & ~state_change;

endmodule

// File: tb/tb_rx_ltssm_substate.sv
// tb/tb_rx_ltssm_substate.sv - bench for rx_ltssm_substate, upstream and downstream instances
module tb_rx_ltssm_substate;

  localparam int TO = 300;
  localparam int QT = 150;
  localparam int IT = 100;
  localparam logic [7:0] PAD = 8'hF7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] substateRx = 4'd0;
  logic osValid = 1'b0;
  logic [1:0] osType = 2'd0;
  logic [7:0] osLinkNumber = 8'd0;
  logic [7:0] osLaneNumber = 8'd0;
  logic [7:0] osRateId = 8'd0;
  logic rxElecIdleExit = 1'b0;
  logic detectDone = 1'b0;
  logic receiverDetected = 1'b0;

  logic [1:0]      fin;
  logic [1:0][3:0] go;
  logic [1:0][7:0] lnk;
  logic [1:0]      wl;
  logic [1:0][7:0] rid;
  logic [1:0]      wr;

  always #5 clk = ~clk;

  rx_ltssm_substate #(.DEVICETYPE(0), .TIMEOUT_CYCLES(TO), .QUIET_CYCLES(QT), .IDLE_TIMEOUT(IT)) u_dut0 (
    .clk(clk), .reset(reset), .substateRx(substateRx), .osValid(osValid), .osType(osType),
    .osLinkNumber(osLinkNumber), .osLaneNumber(osLaneNumber), .osRateId(osRateId),
    .rxElecIdleExit(rxElecIdleExit), .detectDone(detectDone), .receiverDetected(receiverDetected),
    .finishRx(fin[0]), .gotoRx(go[0]), .linkNumberInRx(lnk[0]), .writeLinkNumberRx(wl[0]),
    .rateIdIn(rid[0]), .writeRateId(wr[0])
  );

  rx_ltssm_substate #(.DEVICETYPE(1), .TIMEOUT_CYCLES(TO), .QUIET_CYCLES(QT), .IDLE_TIMEOUT(IT)) u_dut1 (
    .clk(clk), .reset(reset), .substateRx(substateRx), .osValid(osValid), .osType(osType),
    .osLinkNumber(osLinkNumber), .osLaneNumber(osLaneNumber), .osRateId(osRateId),
    .rxElecIdleExit(rxElecIdleExit), .detectDone(detectDone), .receiverDetected(receiverDetected),
    .finishRx(fin[1]), .gotoRx(go[1]), .linkNumberInRx(lnk[1]), .writeLinkNumberRx(wl[1]),
    .rateIdIn(rid[1]), .writeRateId(wr[1])
  );

  // Reference: run length of qualifying sets, cycles spent in substate, pending finish
  int need_tab[10] = '{0, 0, 8, 8, 2, 2, 2, 2, 8, 8};
  int tgt_tab[10]  = '{1, 0, 3, 4, 5, 6, 7, 8, 9, 10};
  int des_tab[16]  = '{0, 0, 1, 2, 1, 1, 1, 2, 2, 3, 0, 0, 0, 0, 0, 0};
  int m_tracked[2], m_run[2], m_timer[2], m_goto[2];
  bit m_fin[2], m_wl[2], m_wr[2];
  logic [7:0] m_link[2], m_rate[2];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit qual(int d, int st);
    bit ts1, ts2;
    ts1 = osType == 2'd1;
    ts2 = osType == 2'd2;
    case (st)
      2: return (ts1 || ts2) && osLaneNumber == PAD;
      3: return ts2;
      4: return ts1 && osLinkNumber != PAD;
      5: return d == 1 && ts1 && osLinkNumber == m_link[d] && osLaneNumber != PAD;
      6: return ts1 && osLaneNumber != PAD;
      7: return ts2;
      8: return ts2 && osLinkNumber == m_link[d];
      9: return osType == 2'd3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_tracked[d] = 0; m_run[d] = 0; m_timer[d] = 0; m_goto[d] = 0;
      m_fin[d] = 0; m_wl[d] = 0; m_wr[d] = 0; m_link[d] = 8'd0; m_rate[d] = 8'd0;
    end
  endtask

  task automatic model_step(int d);
    int st, tgt;
    bit q, osx, tox;
    m_wl[d] = 0;
    m_wr[d] = 0;
    if (int'(substateRx) != m_tracked[d]) begin
      m_tracked[d] = int'(substateRx);
      m_run[d] = 0; m_timer[d] = 0; m_fin[d] = 0;
      return;
    end
    st = m_tracked[d];
    if (st > 9) begin
      m_run[d] = 0; m_timer[d] = 0;
      return;
    end
    q = osValid && qual(d, st);
    osx = q && (m_run[d] + 1 >= need_tab[st]);
    tgt = tgt_tab[st];
    if (st == 0) osx = rxElecIdleExit;
    if (st == 1) begin
      osx = detectDone;
      tgt = receiverDetected ? 2 : 0;
    end
    tox = (st == 0 && m_timer[d] == QT) || (st >= 2 && st <= 8 && m_timer[d] == TO) ||
          (st == 9 && m_timer[d] == IT);
    if (!m_fin[d]) begin
      if (osx) begin
        m_fin[d] = 1; m_goto[d] = tgt;
        if (st == 4 && d == 1) begin m_link[d] = osLinkNumber; m_wl[d] = 1; end
        if (st == 8) begin m_rate[d] = osRateId; m_wr[d] = 1; end
      end else if (tox) begin
        m_fin[d] = 1; m_goto[d] = (st == 0) ? 1 : 0;
      end
    end
    if (osValid) m_run[d] = q ? ((m_run[d] < 15) ? m_run[d] + 1 : 15) : 0;
    m_timer[d]++;
  endtask

  function automatic logic [31:0] exp_pack(int d);
    bit f;
    f = m_fin[d] && (int'(substateRx) == m_tracked[d]);
    return {9'd0, f, 4'(m_goto[d]), m_link[d], m_wl[d], m_rate[d], m_wr[d]};
  endfunction

  task automatic compare_all();
    for (int d = 0; d < 2; d++)
      check($sformatf("dut%0d_outputs_st%0d", d, m_tracked[d]),
            {9'd0, fin[d], go[d], lnk[d], wl[d], rid[d], wr[d]}, exp_pack(d));
  endtask

  // Inputs are set just after a rising edge; outputs are compared 1 ns later
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic quiet_inputs();
    osValid = 0; rxElecIdleExit = 0; detectDone = 0;
  endtask

  task automatic send(logic [1:0] t, logic [7:0] link, logic [7:0] lane, logic [7:0] rate);
    osValid = 1; osType = t; osLinkNumber = link; osLaneNumber = lane; osRateId = rate;
    tick();
    osValid = 0;
  endtask

  task automatic goto_state(logic [3:0] s);
    quiet_inputs();
    substateRx = 4'hF;
    tick();
    substateRx = s;
    tick();
  endtask

  task automatic expect_finish(string tag, int d, bit f, int g);
    check({tag, "_finish"}, 32'(fin[d]), 32'(f));
    if (f) check({tag, "_goto"}, 32'(go[d]), 32'(g));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("reset_goto", 32'(go[1]), 32'd0);
    reset = 1;

    // 1: elec-idle exit in detectQuiet
    repeat (5) tick();
    rxElecIdleExit = 1;
    tick();
    rxElecIdleExit = 0;
    expect_finish("t1", 1, 1, 1);
    substateRx = 4'd1;
    #1;
    check("t1_same_cycle_clear", 32'(fin[1]), 32'd0);
    tick();

    // 2: pollingActive, seven TS1 then a TS2; then a broken run
    goto_state(4'd2);
    repeat (7) send(2'd1, 8'h00, PAD, 8'h00);
    expect_finish("t2_after7", 1, 0, 0);
    send(2'd2, 8'h00, PAD, 8'h00);
    expect_finish("t2_after8", 1, 1, 3);
    goto_state(4'd2);
    repeat (7) send(2'd1, 8'h00, PAD, 8'h00);
    send(2'd0, 8'h00, PAD, 8'h00);
    repeat (7) send(2'd1, 8'h00, PAD, 8'h00);
    expect_finish("t2_restart7", 1, 0, 0);
    send(2'd1, 8'h00, PAD, 8'h00);
    expect_finish("t2_restart8", 1, 1, 3);

    // 3: link-width start captures link number on the upstream port only
    goto_state(4'd4);
    send(2'd1, 8'h05, 8'h00, 8'h00);
    send(2'd1, 8'h05, 8'h00, 8'h00);
    expect_finish("t3_up", 1, 1, 5);
    check("t3_wl_up", 32'(wl[1]), 32'd1);
    check("t3_link_up", 32'(lnk[1]), 32'h05);
    check("t3_wl_down", 32'(wl[0]), 32'd0);
    tick();
    check("t3_wl_pulse", 32'(wl[1]), 32'd0);
    goto_state(4'd5);
    send(2'd1, 8'h05, 8'h01, 8'h00);
    send(2'd1, 8'h05, 8'h01, 8'h00);
    expect_finish("t3_accept_up", 1, 1, 6);
    expect_finish("t3_accept_down", 0, 0, 0);

    // 4: configurationComplete with a wrong link on the 5th TS2
    goto_state(4'd8);
    repeat (4) send(2'd2, 8'h05, 8'h00, 8'h02);
    send(2'd2, 8'h06, 8'h00, 8'h02);
    repeat (7) send(2'd2, 8'h05, 8'h00, 8'h02);
    expect_finish("t4_after7", 1, 0, 0);
    send(2'd2, 8'h05, 8'h00, 8'h02);
    expect_finish("t4_after8", 1, 1, 9);
    check("t4_wr", 32'(wr[1]), 32'd1);
    check("t4_rate", 32'(rid[1]), 32'h02);

    // 5: pollingConfiguration timeout, then a TS2 run ending on the timeout cycle
    goto_state(4'd3);
    repeat (TO) tick();
    expect_finish("t5_before", 1, 0, 0);
    tick();
    expect_finish("t5_timeout", 1, 1, 0);
    goto_state(4'd3);
    repeat (TO - 7) tick();
    repeat (8) send(2'd2, 8'h00, 8'h00, 8'h00);
    expect_finish("t5_collide", 1, 1, 4);

    // 6: configurationIdle to L0, finish held, then reset mid-count
    goto_state(4'd9);
    repeat (8) send(2'd3, 8'h00, 8'h00, 8'h00);
    expect_finish("t6_idle", 1, 1, 10);
    repeat (5) send(2'($urandom_range(0, 3)), 8'h00, 8'h00, 8'h00);
    expect_finish("t6_held", 1, 1, 10);
    goto_state(4'd9);
    repeat (4) send(2'd3, 8'h00, 8'h00, 8'h00);
    reset = 0;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("t6_reset_dut%0d", d), {9'd0, fin[d], go[d], lnk[d], wl[d], rid[d], wr[d]}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;

    // Random walk that mostly follows the commanded exit
    for (int i = 0; i < 4000; i++) begin
      int st, t;
      quiet_inputs();
      if (m_fin[1] && int'(substateRx) == m_tracked[1] && $urandom_range(0, 9) < 7)
        substateRx = 4'(m_goto[1]);
      else if ($urandom_range(0, 99) < 2)
        substateRx = 4'($urandom_range(0, 15));
      st = int'(substateRx);
      rxElecIdleExit = $urandom_range(0, 99) < 3;
      detectDone = $urandom_range(0, 9) == 0;
      receiverDetected = 1'($urandom);
      osValid = $urandom_range(0, 9) < 7;
      t = ($urandom_range(0, 9) < 8) ? des_tab[st] : int'($urandom_range(0, 3));
      if (st == 2 && t == 1 && $urandom_range(0, 1) == 1) t = 2;
      osType = 2'(t);
      osLinkNumber = ($urandom_range(0, 9) < 8) ? m_link[1] : 8'($urandom_range(0, 255));
      if (st == 4) osLinkNumber = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 31)) : PAD;
      osLaneNumber = (st == 2) ? ($urandom_range(0, 9) < 9 ? PAD : 8'h01)
                               : ($urandom_range(0, 9) < 8 ? 8'($urandom_range(0, 15)) : PAD);
      osRateId = 8'($urandom_range(0, 255));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
